// File: rtl/chinx_ioirq.sv
// Edge-triggered interrupt source: synchronizes and debounces an input port, latches
// enabled edges into a pending register and runs the request/ack/EOI handshake.
module chinx_ioirq #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin_i,
  input  logic             ack_i,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  output logic             ireq_o,
  output logic [WIDTH-1:0] pend_o,
  output logic [WIDTH-1:0] level_o
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_pipe;
  logic [WIDTH-1:0]                  sync_lvl;
  logic [WIDTH-1:0][CNT_W-1:0]       cnt_q, cnt_nxt;
  logic [WIDTH-1:0]                  level_q, level_nxt;
  logic [WIDTH-1:0]                  rise_evt, fall_evt, set_evt, w1c_mask;
  logic [WIDTH-1:0]                  pend_q, pend_nxt;
  logic [WIDTH-1:0]                  rise_en_q, fall_en_q;
  logic                              en_q;
  logic                              eoi;
  state_t                            state_q, state_nxt;

  assign sync_lvl = sync_pipe[SYNC_STAGES-1];

  // Debounce: a change is accepted on the edge its counter would reach DEBOUNCE
  always_comb begin
    level_nxt = level_q;
    cnt_nxt   = '0;
    rise_evt  = '0;
    fall_evt  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync_lvl[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_nxt[i] = sync_lvl[i];
          rise_evt[i]  = sync_lvl[i];
          fall_evt[i]  = ~sync_lvl[i];
        end else begin
          cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // A new edge beats a same-cycle write-1-to-clear on the same bit
  assign eoi      = cfg_we && (cfg_addr == 2'd2);
  assign w1c_mask = eoi ? cfg_data : '0;
  assign set_evt  = (rise_evt & rise_en_q) | (fall_evt & fall_en_q);
  assign pend_nxt = (pend_q & ~w1c_mask) | set_evt;

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE: if (en_q && (|pend_q)) state_nxt = REQ;
      REQ: begin
        if (ack_i)                         state_nxt = SERV;
        else if (!en_q || (pend_nxt == '0)) state_nxt = IDLE;
      end
      SERV: if (eoi) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_pipe <= '0;
      cnt_q     <= '0;
      level_q   <= '0;
      pend_q    <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      en_q      <= 1'b0;
      state_q   <= IDLE;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], pin_i};
      cnt_q     <= cnt_nxt;
      level_q   <= level_nxt;
      pend_q    <= pend_nxt;
      state_q   <= state_nxt;
      if (cfg_we && (cfg_addr == 2'd0)) rise_en_q <= cfg_data;
      if (cfg_we && (cfg_addr == 2'd1)) fall_en_q <= cfg_data;
      if (cfg_we && (cfg_addr == 2'd3)) en_q      <= cfg_data[0];
    end
  end

  assign ireq_o  = (state_q == REQ);
  assign pend_o  = pend_q;
  assign level_o = level_q;

endmodule

// File: tb/tb_chinx_ioirq.sv
// Directed bench for chinx_ioirq: edge latency, glitch rejection, enable gating,
// service-time edges, set-vs-clear priority and asynchronous reset.
module tb_chinx_ioirq;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pin_i;
  logic       ack_i;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       ireq_o;
  logic [7:0] pend_o;
  logic [7:0] level_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  chinx_ioirq #(
    .WIDTH      (8),
    .SYNC_STAGES(2),
    .DEBOUNCE   (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pin_i   (pin_i),
    .ack_i   (ack_i),
    .cfg_we  (cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_data(cfg_data),
    .ireq_o  (ireq_o),
    .pend_o  (pend_o),
    .level_o (level_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    tick();
    cfg_we   = 1'b0;
    cfg_addr = 2'd0;
    cfg_data = 8'h00;
  endtask

  task automatic pulse_ack();
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
  endtask

  initial begin
    rst      = 1'b0;
    pin_i    = 8'h00;
    ack_i    = 1'b0;
    cfg_we   = 1'b0;
    cfg_addr = 2'd0;
    cfg_data = 8'h00;
    tick(3);
    check("rst_ireq", ireq_o, 0);
    check("rst_pend", pend_o, 8'h00);
    check("rst_level", level_o, 8'h00);
    rst = 1'b1;
    tick();

    // Basic rise / ack / EOI with edge-exact latency
    cfg_write(2'd0, 8'h01);
    cfg_write(2'd3, 8'h01);
    pin_i = 8'h01;
    tick(5);
    check("lat_level_e5", level_o, 8'h00);
    check("lat_pend_e5", pend_o, 8'h00);
    tick();
    check("lat_level_e6", level_o, 8'h01);
    check("lat_pend_e6", pend_o, 8'h01);
    check("lat_ireq_e6", ireq_o, 0);
    tick();
    check("lat_ireq_e7", ireq_o, 1);
    tick(3);
    check("req_hold", ireq_o, 1);
    pulse_ack();
    check("ack_drop", ireq_o, 0);
    tick(2);
    check("serv_quiet", ireq_o, 0);
    cfg_write(2'd2, 8'h01);
    check("eoi_clear", pend_o, 8'h00);
    tick(2);
    check("idle_after_eoi", ireq_o, 0);
    pulse_ack();
    tick();
    check("ack_in_idle", ireq_o, 0);

    // Glitch rejection then a pulse just long enough
    cfg_write(2'd0, 8'hFF);
    pin_i = 8'h09;
    tick(3);
    pin_i = 8'h01;
    tick(10);
    check("glitch_level", level_o, 8'h01);
    check("glitch_pend", pend_o, 8'h00);
    check("glitch_ireq", ireq_o, 0);
    pin_i = 8'h09;
    tick(4);
    pin_i = 8'h01;
    tick(2);
    check("pulse4_pend", pend_o, 8'h08);
    check("pulse4_level", level_o, 8'h09);
    tick();
    check("pulse4_ireq", ireq_o, 1);
    tick(10);
    check("pulse4_fall_level", level_o, 8'h01);
    check("pulse4_fall_pend", pend_o, 8'h08);
    pulse_ack();
    cfg_write(2'd2, 8'h08);
    check("pulse4_eoi", pend_o, 8'h00);

    // Falling edge latched with EN=0, request only once EN is set
    cfg_write(2'd3, 8'h00);
    cfg_write(2'd0, 8'h00);
    cfg_write(2'd1, 8'h80);
    pin_i = 8'h81;
    tick(10);
    check("fall_settle_level", level_o, 8'h81);
    check("fall_settle_pend", pend_o, 8'h00);
    pin_i = 8'h01;
    tick(10);
    check("fall_pend", pend_o, 8'h80);
    check("fall_level", level_o, 8'h01);
    check("fall_ireq_gated", ireq_o, 0);
    cfg_write(2'd3, 8'h01);
    check("en_write_edge", ireq_o, 0);
    tick();
    check("en_ireq", ireq_o, 1);

    // New edge while in service: latched but not requested until EOI
    pulse_ack();
    check("serv_ack", ireq_o, 0);
    cfg_write(2'd0, 8'h04);
    pin_i = 8'h05;
    tick(10);
    check("serv_pend", pend_o, 8'h84);
    check("serv_level", level_o, 8'h05);
    check("serv_ireq", ireq_o, 0);
    cfg_write(2'd2, 8'h80);
    check("serv_eoi_pend", pend_o, 8'h04);
    check("serv_eoi_ireq", ireq_o, 0);
    tick();
    check("serv_rereq", ireq_o, 1);
    pulse_ack();
    cfg_write(2'd2, 8'h04);
    check("serv_final_pend", pend_o, 8'h00);

    // Set and W1C on the same bit in the same cycle
    cfg_write(2'd0, 8'h06);
    pin_i = 8'h07;
    tick(5);
    cfg_write(2'd2, 8'h02);
    check("setclr_pend", pend_o, 8'h02);
    check("setclr_level", level_o, 8'h07);
    tick();
    check("setclr_ireq", ireq_o, 1);

    // Asynchronous reset mid-request
    #3;
    rst = 1'b0;
    #1;
    check("arst_ireq", ireq_o, 0);
    check("arst_pend", pend_o, 8'h00);
    check("arst_level", level_o, 8'h00);
    pin_i = 8'h00;
    tick(2);
    rst = 1'b1;
    tick(12);
    check("post_rst_ireq", ireq_o, 0);
    check("post_rst_pend", pend_o, 8'h00);
    check("post_rst_level", level_o, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
